// File: rtl/in_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : in_port_pkg
// Description : Shared constants and helpers for the multi-channel input port.
//               Holds the status-word bit positions and a ceil-log2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package in_port_pkg;

    // Bit positions inside the status word returned when stat_rd=1
    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_CNT_LSB = 2;
    localparam int ST_CNT_W   = 6;
    localparam int ST_UF_LSB  = 8;
    localparam int ST_NE_LSB  = 16;

    // ceil(log2(n)) with a floor of 1 so a one-channel port still has a select bit
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 16; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/in_port_fifo.sv
`default_nettype none
// ============================================================================
// Module      : in_port_fifo
// Description : One input channel: DEPTH-entry FIFO with valid/ready push,
//               CPU pop, hold register of the last popped word and a sticky
//               underflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module in_port_fifo
    import in_port_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int PW     = clog2_min1(DEPTH),
    localparam int CNTW   = PW + 1
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic              pop,
    input  logic              stat_clr,
    output logic [DATA_W-1:0] head,
    output logic [DATA_W-1:0] hold,
    output logic [CNTW-1:0]   count,
    output logic              empty,
    output logic              full,
    output logic              underflow
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CNTW-1:0]   r_count;
    logic [DATA_W-1:0] r_hold;
    logic              r_uf;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_uf;

    assign w_full  = (r_count == CNTW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Ready is held low for the whole reset so no word is taken while clearing
    assign push_ready = ~w_full & clr_n;
    assign w_push     = push_valid & push_ready;
    assign w_pop      = pop & ~w_empty;
    assign w_uf       = pop & w_empty;

    // Storage array: written on accepted pushes, no reset needed
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

    // Pointers, occupancy, hold register and sticky underflow
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hold   <= '0;
            r_uf     <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_hold   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
            // A new underflow on the same edge as a clear must survive
            if (w_uf)          r_uf <= 1'b1;
            else if (stat_clr) r_uf <= 1'b0;
        end
    end

    assign head      = r_mem[r_rd_ptr];
    assign hold      = r_hold;
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign underflow = r_uf;

endmodule
`default_nettype wire

// File: rtl/multi_in_port.sv
`default_nettype none
// ============================================================================
// Module      : multi_in_port
// Description : CHANNELS-wide input port. Per-channel FIFOs, CPU-side select
//               mux onto the bus, status word assembly and a registered
//               level interrupt for pending data.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_in_port
    import in_port_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 4,
    parameter int CW       = clog2_min1(CHANNELS)
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic [CHANNELS*DATA_W-1:0] dev_data,
    input  logic [CHANNELS-1:0]        dev_valid,
    output logic [CHANNELS-1:0]        dev_ready,
    input  logic [CW-1:0]              ch_sel,
    input  logic                       in_pop,
    input  logic                       stat_rd,
    input  logic                       stat_clr,
    input  logic [CHANNELS-1:0]        irq_en,
    output logic [DATA_W-1:0]          bus_data,
    output logic                       in_empty,
    output logic                       in_irq
);

    localparam int CNTW = clog2_min1(DEPTH) + 1;

    logic [DATA_W-1:0]   w_head  [CHANNELS];
    logic [DATA_W-1:0]   w_hold  [CHANNELS];
    logic [CNTW-1:0]     w_count [CHANNELS];
    logic [CHANNELS-1:0] w_empty;
    logic [CHANNELS-1:0] w_full;
    logic [CHANNELS-1:0] w_uf;
    logic [CHANNELS-1:0] w_pop;
    logic [CHANNELS-1:0] w_ne;

    logic [DATA_W-1:0]   w_sel_head;
    logic [DATA_W-1:0]   w_sel_hold;
    logic [CNTW-1:0]     w_sel_count;
    logic                w_sel_empty;
    logic                w_sel_full;
    logic [DATA_W-1:0]   w_status;
    logic                r_irq;

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
            assign w_pop[k] = in_pop & (ch_sel == CW'(k));

            in_port_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clk        (clk),
                .clr_n      (clr_n),
                .push_data  (dev_data[k*DATA_W +: DATA_W]),
                .push_valid (dev_valid[k]),
                .push_ready (dev_ready[k]),
                .pop        (w_pop[k]),
                .stat_clr   (stat_clr),
                .head       (w_head[k]),
                .hold       (w_hold[k]),
                .count      (w_count[k]),
                .empty      (w_empty[k]),
                .full       (w_full[k]),
                .underflow  (w_uf[k])
            );
        end
    endgenerate

    assign w_ne = ~w_empty;

    // Channel select mux; an unpopulated select value reads as an empty idle port
    always_comb begin
        w_sel_head  = '0;
        w_sel_hold  = '0;
        w_sel_count = '0;
        w_sel_empty = 1'b1;
        w_sel_full  = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ch_sel == CW'(k)) begin
                w_sel_head  = w_head[k];
                w_sel_hold  = w_hold[k];
                w_sel_count = w_count[k];
                w_sel_empty = w_empty[k];
                w_sel_full  = w_full[k];
            end
        end
    end

    // Status word assembly, zero-extended to the bus width
    always_comb begin
        w_status                            = '0;
        w_status[ST_EMPTY]                  = w_sel_empty;
        w_status[ST_FULL]                   = w_sel_full;
        w_status[ST_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(w_sel_count);
        w_status[ST_UF_LSB +: CHANNELS]     = w_uf;
        w_status[ST_NE_LSB +: CHANNELS]     = w_ne;
    end

    // Idle port repeats the last popped word, as the legacy single register did
    assign bus_data = stat_rd     ? w_status   :
                      w_sel_empty ? w_sel_hold : w_sel_head;
    assign in_empty = w_sel_empty;

    // Level interrupt: any enabled channel holding data, one cycle late
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) r_irq <= 1'b0;
        else        r_irq <= |(w_ne & irq_en);
    end

    assign in_irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_multi_in_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_in_port
// Description : Directed plus randomized bench for multi_in_port, checked
//               against a queue-based reference model of the port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_in_port;

    localparam int DW    = 32;
    localparam int CH    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 2;

    logic             clk = 1'b0;
    logic             clr_n;
    logic [CH*DW-1:0] dev_data;
    logic [CH-1:0]    dev_valid;
    logic [CH-1:0]    dev_ready;
    logic [CW-1:0]    ch_sel;
    logic             in_pop;
    logic             stat_rd;
    logic             stat_clr;
    logic [CH-1:0]    irq_en;
    logic [DW-1:0]    bus_data;
    logic             in_empty;
    logic             in_irq;

    multi_in_port #(
        .DATA_W   (DW),
        .CHANNELS (CH),
        .DEPTH    (DEPTH),
        .CW       (CW)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .dev_data  (dev_data),
        .dev_valid (dev_valid),
        .dev_ready (dev_ready),
        .ch_sel    (ch_sel),
        .in_pop    (in_pop),
        .stat_rd   (stat_rd),
        .stat_clr  (stat_clr),
        .irq_en    (irq_en),
        .bus_data  (bus_data),
        .in_empty  (in_empty),
        .in_irq    (in_irq)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per channel plus hold words and flags
    logic [31:0]   mq [CH][$];
    logic [31:0]   m_hold [CH];
    logic [CH-1:0] m_uf;
    logic          m_irq;
    logic [CH-1:0] m_pushed;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            mq[k].delete();
            m_hold[k] = '0;
        end
        m_uf     = '0;
        m_irq    = 1'b0;
        m_pushed = '0;
    endtask

    function automatic logic [CH-1:0] m_ready();
        logic [CH-1:0] r;
        for (int k = 0; k < CH; k++) r[k] = clr_n && (mq[k].size() != DEPTH);
        return r;
    endfunction

    function automatic logic [CH-1:0] m_ne();
        logic [CH-1:0] r;
        for (int k = 0; k < CH; k++) r[k] = (mq[k].size() != 0);
        return r;
    endfunction

    function automatic logic [31:0] m_status(input int s);
        int          cnt;
        logic [31:0] st;
        cnt = mq[s].size();
        st  = 32'(cnt) * 4;
        if (cnt == 0)     st = st + 1;
        if (cnt == DEPTH) st = st + 2;
        st = st + 32'(m_uf)   * 256;
        st = st + 32'(m_ne()) * 65536;
        return st;
    endfunction

    function automatic logic [31:0] m_bus();
        int s;
        s = int'(ch_sel);
        if (stat_rd)            return m_status(s);
        if (mq[s].size() != 0)  return mq[s][0];
        return m_hold[s];
    endfunction

    // Advance the model by one rising edge using the currently driven inputs
    task automatic model_edge();
        logic [CH-1:0] rdy;
        logic          nxt_irq;
        int            s;
        rdy      = m_ready();
        nxt_irq  = |(m_ne() & irq_en);
        m_pushed = '0;
        s        = int'(ch_sel);
        if (stat_clr) m_uf = '0;
        if (in_pop) begin
            if (mq[s].size() == 0) m_uf[s] = 1'b1;
            else                   m_hold[s] = mq[s].pop_front();
        end
        for (int k = 0; k < CH; k++) begin
            if (dev_valid[k] && rdy[k]) begin
                mq[k].push_back(dev_data[k*DW +: DW]);
                m_pushed[k] = 1'b1;
            end
        end
        m_irq = nxt_irq;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_bus"},   bus_data,  m_bus());
        check({tag, "_empty"}, in_empty,  mq[int'(ch_sel)].size() == 0);
        check({tag, "_ready"}, dev_ready, m_ready());
        check({tag, "_irq"},   in_irq,    m_irq);
    endtask

    // Called at posedge+1 with inputs set; checks at +3 then crosses the edge
    task automatic cyc(input string tag);
        #2;
        check_all(tag);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int v;
        clr_n     = 1'b0;
        dev_data  = '0;
        dev_valid = '0;
        ch_sel    = '0;
        in_pop    = 1'b0;
        stat_rd   = 1'b0;
        stat_clr  = 1'b0;
        irq_en    = '0;
        model_reset();

        // Reset state while clr_n is low
        #3;
        check("rst_ready", dev_ready, 4'b0000);
        check("rst_bus",   bus_data,  32'h0);
        check("rst_empty", in_empty,  1'b1);
        check("rst_irq",   in_irq,    1'b0);
        @(posedge clk);
        #1;
        clr_n = 1'b1;

        // 1: idle after release
        #1;
        check("t1_ready", dev_ready, 4'b1111);
        check("t1_bus",   bus_data,  32'h0);
        check("t1_empty", in_empty,  1'b1);
        cyc("t1");

        // 2: push 39..41 on channel 2, pop them back in order
        dev_valid = 4'b0100;
        for (int i = 39; i <= 41; i++) begin
            dev_data[2*DW +: DW] = 32'(i);
            cyc("t2_push");
        end
        dev_valid = '0;
        ch_sel    = 2'd2;
        in_pop    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_pop_val", bus_data, 32'(39 + i));
            cyc("t2_pop");
        end
        in_pop = 1'b0;
        #1;
        check("t2_empty_after", in_empty, 1'b1);
        check("t2_hold_after",  bus_data, 32'd41);
        cyc("t2_idle");

        // 3: device holds valid on channel 1; fills to DEPTH and waits
        dev_valid = 4'b0010;
        v = 1;
        for (int i = 0; i < 6; i++) begin
            dev_data[1*DW +: DW] = 32'(v);
            cyc("t3_fill");
            if (m_pushed[1]) v++;
        end
        stat_rd = 1'b1;
        ch_sel  = 2'd1;
        #1;
        check("t3_ready1_low", dev_ready[1], 1'b0);
        check("t3_status",     bus_data,     32'h0002_0012);
        cyc("t3_stat");
        stat_rd = 1'b0;
        in_pop  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            #1;
            check("t3_pop_val", bus_data, 32'(i));
            cyc("t3_pop");
            if (m_pushed[1]) dev_valid = '0;
        end
        in_pop    = 1'b0;
        dev_valid = '0;
        cyc("t3_idle");

        // 4: underflow on empty channel 3, clear, and set-beats-clear
        ch_sel = 2'd3;
        in_pop = 1'b1;
        cyc("t4_uf");
        in_pop  = 1'b0;
        stat_rd = 1'b1;
        #1;
        check("t4_uf_set",   32'(bus_data[11]),  32'd1);
        check("t4_cnt_zero", 32'(bus_data[7:0]), 32'h01);
        cyc("t4_stat");
        stat_clr = 1'b1;
        cyc("t4_clr");
        stat_clr = 1'b0;
        #1;
        check("t4_uf_cleared", 32'(bus_data[11]), 32'd0);
        cyc("t4_after_clr");
        in_pop   = 1'b1;
        stat_clr = 1'b1;
        cyc("t4_both");
        in_pop   = 1'b0;
        stat_clr = 1'b0;
        #1;
        check("t4_set_wins", 32'(bus_data[11]), 32'd1);
        cyc("t4_after_both");
        stat_clr = 1'b1;
        cyc("t4_reclr");
        stat_clr = 1'b0;
        stat_rd  = 1'b0;

        // 5: interrupt only for enabled channel, one cycle after the push
        irq_en    = 4'b0100;
        dev_valid = 4'b0001;
        dev_data[0*DW +: DW] = $urandom;
        cyc("t5_ch0");
        dev_valid = '0;
        cyc("t5_wait");
        #1;
        check("t5_ch0_no_irq", in_irq, 1'b0);
        cyc("t5_wait2");
        dev_valid = 4'b0100;
        dev_data[2*DW +: DW] = $urandom;
        cyc("t5_ch2");
        dev_valid = '0;
        #1;
        check("t5_irq_not_yet", in_irq, 1'b0);
        cyc("t5_lat");
        #1;
        check("t5_irq_set", in_irq, 1'b1);
        ch_sel = 2'd2;
        in_pop = 1'b1;
        cyc("t5_drain2");
        ch_sel = 2'd0;
        cyc("t5_drain0");
        in_pop = 1'b0;
        irq_en = '0;
        cyc("t5_idle");

        // 6: reset mid-stream with channel 1 holding three words
        dev_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            dev_data[1*DW +: DW] = $urandom;
            cyc("t6_fill");
        end
        dev_valid = '0;
        ch_sel    = 2'd1;
        #1;
        check("t6_pre_count", 32'(mq[1].size()), 32'd3);
        check("t6_pre_bus",   bus_data,          mq[1][0]);
        clr_n = 1'b0;
        #1;
        model_reset();
        check("t6_rst_ready", dev_ready, 4'b0000);
        check("t6_rst_bus",   bus_data,  32'h0);
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        #1;
        check("t6_rel_ready", dev_ready, 4'b1111);
        check("t6_rel_bus",   bus_data,  32'h0);
        stat_rd = 1'b1;
        cyc("t6_stat");
        stat_rd = 1'b0;
        cyc("t6_idle");

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            dev_valid = 4'($urandom & $urandom);
            for (int k = 0; k < CH; k++) dev_data[k*DW +: DW] = $urandom;
            ch_sel   = 2'($urandom_range(0, 3));
            in_pop   = ($urandom_range(0, 2) == 0);
            stat_rd  = ($urandom_range(0, 3) == 0);
            stat_clr = ($urandom_range(0, 15) == 0);
            irq_en   = 4'($urandom);
            cyc("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
